// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder. The master drives operands and the
// downstream ready; the slave (the adder) drives its ready and the result.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iCin;
  logic             iSub;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oSum;
  logic             oCout;
  logic             oOvf;
  logic             oZero;

  modport master (
    output iValid, iA, iB, iCin, iSub, iReady,
    input  oReady, oValid, oSum, oCout, oOvf, oZero
  );

  modport slave (
    input  iValid, iA, iB, iCin, iSub, iReady,
    output oReady, oValid, oSum, oCout, oOvf, oZero
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers bit and group generate/propagate; stage 2 resolves carries and flags.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input logic             iClk,
  input logic             iRst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int unsigned NumGroups = WIDTH / GROUP;

  // Stage 1 combinational terms
  logic [WIDTH-1:0]     bx;
  logic [WIDTH-1:0]     bit_g;
  logic [WIDTH-1:0]     bit_p;
  logic [NumGroups-1:0] grp_g;
  logic [NumGroups-1:0] grp_p;

  // Stage 1 registers
  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_g_q, s1_g_d;
  logic [WIDTH-1:0]     s1_p_q, s1_p_d;
  logic [NumGroups-1:0] s1_gg_q, s1_gg_d;
  logic [NumGroups-1:0] s1_gp_q, s1_gp_d;
  logic                 s1_c0_q, s1_c0_d;
  logic                 s1_amsb_q, s1_amsb_d;
  logic                 s1_bmsb_q, s1_bmsb_d;

  // Stage 2 combinational terms
  logic [NumGroups:0]   grp_c;
  logic [WIDTH-1:0]     carry;
  logic                 c_run;
  logic [WIDTH-1:0]     sum;

  // Stage 2 registers
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;

  logic s1_adv, s2_adv, s1_load, s2_load;

  assign s2_adv  = !s2_valid_q || bus.iReady;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign s1_load = s1_adv && bus.iValid;
  assign s2_load = s2_adv && s1_valid_q;

  always_comb begin
    bx    = bus.iSub ? ~bus.iB : bus.iB;
    bit_g = bus.iA & bx;
    bit_p = bus.iA ^ bx;
    grp_g = '0;
    grp_p = '0;
    // Unrolled per-group lookahead: G = g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0, P = &p
    for (int k = 0; k < NumGroups; k++) begin
      grp_g[k] = 1'b0;
      grp_p[k] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        grp_g[k] = bit_g[k*GROUP+i] | (bit_p[k*GROUP+i] & grp_g[k]);
        grp_p[k] = grp_p[k] & bit_p[k*GROUP+i];
      end
    end
  end

  always_comb begin
    grp_c    = '0;
    carry    = '0;
    c_run    = 1'b0;
    grp_c[0] = s1_c0_q;
    for (int k = 0; k < NumGroups; k++) begin
      grp_c[k+1] = s1_gg_q[k] | (s1_gp_q[k] & grp_c[k]);
    end
    // In-group carries seeded from each group's carry-in
    for (int k = 0; k < NumGroups; k++) begin
      c_run = grp_c[k];
      for (int i = 0; i < GROUP; i++) begin
        carry[k*GROUP+i] = c_run;
        c_run = s1_g_q[k*GROUP+i] | (s1_p_q[k*GROUP+i] & c_run);
      end
    end
    sum = s1_p_q ^ carry;
  end

  always_comb begin
    s1_valid_d = s1_adv ? bus.iValid : s1_valid_q;
    s1_g_d     = s1_g_q;
    s1_p_d     = s1_p_q;
    s1_gg_d    = s1_gg_q;
    s1_gp_d    = s1_gp_q;
    s1_c0_d    = s1_c0_q;
    s1_amsb_d  = s1_amsb_q;
    s1_bmsb_d  = s1_bmsb_q;
    if (s1_load) begin
      s1_g_d    = bit_g;
      s1_p_d    = bit_p;
      s1_gg_d   = grp_g;
      s1_gp_d   = grp_p;
      s1_c0_d   = bus.iCin ^ bus.iSub;
      s1_amsb_d = bus.iA[WIDTH-1];
      s1_bmsb_d = bx[WIDTH-1];
    end

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (s2_load) begin
      sum_d  = sum;
      cout_d = grp_c[NumGroups];
      ovf_d  = (s1_amsb_q == s1_bmsb_q) && (sum[WIDTH-1] != s1_amsb_q);
      zero_d = ~|sum;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_valid_q <= 1'b0;
      s1_g_q     <= '0;
      s1_p_q     <= '0;
      s1_gg_q    <= '0;
      s1_gp_q    <= '0;
      s1_c0_q    <= 1'b0;
      s1_amsb_q  <= 1'b0;
      s1_bmsb_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_g_q     <= s1_g_d;
      s1_p_q     <= s1_p_d;
      s1_gg_q    <= s1_gg_d;
      s1_gp_q    <= s1_gp_d;
      s1_c0_q    <= s1_c0_d;
      s1_amsb_q  <= s1_amsb_d;
      s1_bmsb_q  <= s1_bmsb_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.oReady = s1_adv;
  assign bus.oValid = s2_valid_q;
  assign bus.oSum   = sum_q;
  assign bus.oCout  = cout_q;
  assign bus.oOvf   = ovf_q;
  assign bus.oZero  = zero_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed 32/4 vector table, backpressure and mid-flight reset
// sequences, and a random-handshake run on an 8/2 instance against an integer model.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(32)) bus ();
  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut (.iClk(clk), .iRst_n(rst_n), .bus(bus));

  cla_pipe_adder_if #(.WIDTH(8)) bus8 ();
  cla_pipe_adder #(.WIDTH(8), .GROUP(2)) dut8 (.iClk(clk), .iRst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[10];
  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp8;
  logic [10:0] q8[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] s, input logic c,
                           input logic o, input logic z);
    check({tag, " oValid"}, bus.oValid, 1'b1);
    check({tag, " oSum"}, bus.oSum, s);
    check({tag, " oCout"}, bus.oCout, c);
    check({tag, " oOvf"}, bus.oOvf, o);
    check({tag, " oZero"}, bus.oZero, z);
  endtask

  function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int r;
    int sr;
    logic [7:0] s;
    logic c;
    if (!sub) begin
      r  = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      c  = (r > 255);
    end else begin
      r  = ua - ub - int'(cin);
      sr = sa - sb - int'(cin);
      c  = (r >= 0);
    end
    s = 8'(r);
    return {s, c, (sr > 127 || sr < -128), (s == 8'h00)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h7, 32'h7, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h7, 32'h2, 1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};

    bus.iValid = 1'b0; bus.iA = '0; bus.iB = '0; bus.iCin = 1'b0; bus.iSub = 1'b0;
    bus.iReady = 1'b1;
    bus8.iValid = 1'b0; bus8.iA = '0; bus8.iB = '0; bus8.iCin = 1'b0; bus8.iSub = 1'b0;
    bus8.iReady = 1'b1;

    #12;
    check("reset oValid", bus.oValid, 1'b0);
    check("reset oReady", bus.oReady, 1'b1);
    check("reset oSum", bus.oSum, 32'h0);
    check("reset oCout", bus.oCout, 1'b0);
    check("reset oOvf", bus.oOvf, 1'b0);
    check("reset oZero", bus.oZero, 1'b0);
    rst_n = 1'b1;
    step();

    // Directed table: accept, no result one cycle later, result two cycles after accept
    for (int i = 0; i < 10; i++) begin
      bus.iA = vecs[i].a; bus.iB = vecs[i].b; bus.iCin = vecs[i].cin; bus.iSub = vecs[i].sub;
      bus.iValid = 1'b1;
      #1;
      check($sformatf("vec%0d oReady", i), bus.oReady, 1'b1);
      step();
      bus.iValid = 1'b0;
      check($sformatf("vec%0d early oValid", i), bus.oValid, 1'b0);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero);
    end
    step();
    check("idle oValid", bus.oValid, 1'b0);

    // Backpressure: four adds 1+2, 3+4, 10+20, 100+200 with the sink stalled
    bus.iReady = 1'b0; bus.iSub = 1'b0; bus.iCin = 1'b0;
    bus.iA = 32'd1; bus.iB = 32'd2; bus.iValid = 1'b1;
    #1; check("bp accept0 oReady", bus.oReady, 1'b1);
    step();
    bus.iA = 32'd3; bus.iB = 32'd4;
    #1; check("bp accept1 oReady", bus.oReady, 1'b1);
    step();
    bus.iA = 32'd10; bus.iB = 32'd20;
    #1; check("bp full oReady", bus.oReady, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp hold%0d oSum", i), bus.oSum, 32'd3);
      check($sformatf("bp hold%0d oValid", i), bus.oValid, 1'b1);
      check($sformatf("bp hold%0d oReady", i), bus.oReady, 1'b0);
    end
    bus.iReady = 1'b1;
    #1; check("bp release oReady", bus.oReady, 1'b1);
    step();
    check_out("bp res1", 32'd7, 1'b0, 1'b0, 1'b0);
    bus.iA = 32'd100; bus.iB = 32'd200;
    step();
    check_out("bp res2", 32'd30, 1'b0, 1'b0, 1'b0);
    bus.iValid = 1'b0;
    step();
    check_out("bp res3", 32'd300, 1'b0, 1'b0, 1'b0);
    step();
    check("bp drained oValid", bus.oValid, 1'b0);

    // Reset while two operations are in flight
    bus.iReady = 1'b0; bus.iA = 32'd5; bus.iB = 32'd6; bus.iValid = 1'b1;
    step();
    step();
    bus.iValid = 1'b0;
    check("rst pre oValid", bus.oValid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async oValid", bus.oValid, 1'b0);
    check("rst async oReady", bus.oReady, 1'b1);
    check("rst async oSum", bus.oSum, 32'h0);
    #4;
    rst_n = 1'b1;
    bus.iReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rst stale%0d oValid", i), bus.oValid, 1'b0);
    end

    // Random operands and handshake on the 8/2 instance
    for (int it = 0; it < 3000; it++) begin
      bus8.iValid = 1'($urandom_range(0, 1));
      bus8.iA     = 8'($urandom);
      bus8.iB     = 8'($urandom);
      bus8.iCin   = 1'($urandom_range(0, 1));
      bus8.iSub   = 1'($urandom_range(0, 1));
      bus8.iReady = ($urandom_range(0, 3) != 0);
      #1;
      if (bus8.oValid && bus8.iReady) begin
        if (q8.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rand8 spurious: got result %0h, expected none", bus8.oSum);
        end else begin
          exp8 = q8.pop_front();
          check("rand8 result", {bus8.oSum, bus8.oCout, bus8.oOvf, bus8.oZero}, exp8);
        end
      end
      if (bus8.iValid && bus8.oReady) begin
        q8.push_back(model8(bus8.iA, bus8.iB, bus8.iCin, bus8.iSub));
      end
      step();
    end
    bus8.iValid = 1'b0;
    bus8.iReady = 1'b1;
    for (int it = 0; it < 4; it++) begin
      #1;
      if (bus8.oValid) begin
        if (q8.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rand8 drain spurious: got result %0h, expected none", bus8.oSum);
        end else begin
          exp8 = q8.pop_front();
          check("rand8 drain", {bus8.oSum, bus8.oCout, bus8.oOvf, bus8.oZero}, exp8);
        end
      end
      step();
    end
    check("rand8 leftover", q8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor. Successor to the fixed 2-bit and 4-bit lookahead cells.
- Generalises width and group size and adds subtract mode, signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Serves as the mantissa/exponent adder datapath for the floating-point add and sub units.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of GROUP and at least GROUP.
- GROUP, 4, lookahead group size. Legal values are 2 or 4.

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iValid  in  1  upstream operands valid.
- oReady  out  1  block can accept operands this cycle.
- iA  in  WIDTH  operand A.
- iB  in  WIDTH  operand B.
- iCin  in  1  carry-in (borrow-in when iSub=1).
- iSub  in  1  0 = A+B+Cin; 1 = A-B-Cin.
- oValid  out  1  result valid.
- iReady  in  1  downstream accepts the result.
- oSum  out  WIDTH  result.
- oCout  out  1  raw carry out of the MSB (for subtraction, 1 = no borrow).
- oOvf  out  1  two's-complement signed overflow.
- oZero  out  1  oSum == 0.

Behaviour:
- Effective operands:
  - Bx = iSub ? ~iB : iB.
  - c0 = iCin ^ iSub.
- Stage 1 (accept cycle), registered:
  - Per-bit g = A&Bx and p = A^Bx.
  - Per-group G/P via the standard 2- or 4-bit lookahead equations.
  - Register per-bit p, per-group G/P, c0, A[MSB] and Bx[MSB].
- Stage 2, registered:
  - Second-level lookahead over the WIDTH/GROUP groups yields the group carry-ins.
  - In-group carries are derived from those group carry-ins.
  - sum = p ^ carry. Cout = carry out of the MSB.
  - Ovf = (A[MSB] == Bx[MSB]) && (sum[MSB] != A[MSB]).
  - Zero = ~|sum.
- Latency:
  - Result is presented exactly 2 cycles after acceptance when there is no stall.
  - Throughput is 1 operation per cycle.
- Handshake:
  - A transfer occurs on a rising edge when valid && ready, on either side.
  - Stage 2 advances when !s2_valid || iReady.
  - Stage 1 advances when !s1_valid || stage 2 advances.
  - oReady = stage-1 advance condition. It is combinational from iReady; no combinational path exists from iValid to oReady.
  - A stalled stage holds its data and valid unchanged.
  - oSum, oCout, oOvf and oZero stay stable while oValid=1 and iReady=0.
  - iA, iB, iCin and iSub are sampled only on an accepted cycle. When not accepted they are don't-care.
- Simultaneous events:
  - Accept and emit in the same cycle: the pipeline shifts, there are no bubbles, and occupancy is unchanged.
  - Full pipeline with iReady=0: oReady=0 and nothing is dropped or duplicated.
  - When iReady returns to 1, oReady=1 in the same cycle.
- Reset:
  - Asynchronous assert clears s1_valid, s2_valid, oValid=0, oSum=0, oCout=0, oOvf=0 and oZero=0.
  - oReady=1 during and after reset (pipeline empty).
  - Reset mid-operation discards all in-flight operations.
  - Release is used synchronously; the first accept is possible on the first rising edge after release.
- Width rules:
  - No sign extension. The sum wraps modulo 2^WIDTH.
  - Flags are computed on the WIDTH-bit result only.

Test Plan:
- WIDTH=32, GROUP=4:
  - A=32'hFFFF_FFFF, B=1, Cin=0, Sub=0 → Sum=0, Cout=1, Zero=1, Ovf=0, with oValid exactly 2 cycles after accept.
  - A=32'h7FFF_FFFF, B=1, Sub=0 → Sum=32'h8000_0000, Ovf=1, Cout=0.
  - Sub: A=5, B=7, Cin=0 → Sum=32'hFFFF_FFFE, Cout=0, Ovf=0.
  - Sub: A=7, B=7, Cin=0 → Sum=0, Zero=1, Cout=1.
  - Sub: A=7, B=2, Cin=1 → Sum=4.
- Backpressure:
  - Stream 4 back-to-back ops with iReady=0 → oReady drops after 2 accepts and oSum holds the first result stable.
  - Raise iReady → all 4 results appear in order with no loss or duplication.
- Reset mid-flight: assert iRst_n=0 asynchronously while 2 ops are in flight → oValid=0 immediately; after release no stale result appears.
- Parameter sweep:
  - Configurations (WIDTH,GROUP) = (8,2), (16,4), (64,4).
  - 10k random ops each with random iValid/iReady, checked against a behavioural reference model for A±B±Cin.
  - Compare Sum, Cout, Ovf and Zero.
